nn_layer_engine: RTL and testbench

// Parametrised multi-layer fully-connected inference engine. Replaces the fixed
// 15-node feedforward datapath and controller. NUM_NODES parallel MAC lanes run
// NUM_LAYERS dense layers in sequence: pixel input -> hidden layers -> output

---
 rtl/nn_layer_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_nn_layer_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_engine.sv
// nn_layer_engine: multi-layer fully-connected inference engine.
//
// NUM_NODES parallel MAC lanes evaluate NUM_LAYERS dense layers in sequence
// (pixels -> hidden layers -> output layer). Each layer streams its inputs
// plus one bias input of 1.0 against a weight row per input. Accumulation is
// full precision. Each layer result is requantised with saturation. Hidden
// layers apply ReLU. A registered argmax selects the winning output class.
//
// Ports
//   clk        clock
//   reset      synchronous, active-low reset
//   start      begin an inference (sampled only when idle)
//   busy       inference in progress
//   done       one-cycle pulse when scores/class_idx are valid
//   pix_addr   pixel memory address (driven during layer 0, held otherwise)
//   pix_data   unsigned pixel, one-cycle read latency
//   w_layer    weight ROM select (current layer index)
//   w_addr     weight row address; row N_l holds the bias row
//   w_data     weight row, lane i at [DW*i +: DW], one-cycle read latency
//   scores     output-layer results, class c at [DW*c +: DW]
//   class_idx  argmax of scores (lowest index wins ties)
//   overflow   sticky saturation flag for the current/last inference
module nn_layer_engine #(
  parameter int IN_LEN     = 256,
  parameter int NUM_NODES  = 15,
  parameter int OUT_NODES  = 10,
  parameter int NUM_LAYERS = 3,
  parameter int DW         = 16,
  parameter int FRAC       = 12,
  parameter int PIX_SHIFT  = 4,
  parameter int ADR_W      = $clog2(IN_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [ADR_W-1:0]              pix_addr,
  input  logic [7:0]                    pix_data,
  output logic [$clog2(NUM_LAYERS)-1:0] w_layer,
  output logic [ADR_W-1:0]              w_addr,
  input  logic [NUM_NODES*DW-1:0]       w_data,
  output logic [OUT_NODES*DW-1:0]       scores,
  output logic [$clog2(OUT_NODES)-1:0]  class_idx,
  output logic                          overflow
);

  localparam int LW = $clog2(NUM_LAYERS);
  localparam int CW = $clog2(OUT_NODES);
  localparam int NW = $clog2(NUM_NODES);
  localparam int AW = 2 * DW + ADR_W;

  localparam logic [ADR_W-1:0]     LEN_IN     = ADR_W'(IN_LEN);
  localparam logic [ADR_W-1:0]     LEN_HID    = ADR_W'(NUM_NODES);
  localparam logic [LW-1:0]        LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic signed [DW-1:0] ONE        = DW'(1 << FRAC);
  localparam logic signed [AW-1:0] Q_MAX      = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] Q_MIN      = AW'(-(1 << (DW - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_FLUSH, S_WRITE, S_ARGMAX, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          layer_q, layer_d;
  logic [ADR_W-1:0]       k_q, k_d;
  logic [ADR_W-1:0]       pix_addr_q, pix_addr_d;
  logic                   vld_q, vld_d;     // memory data for kd_q is on the bus
  logic                   bias_q, bias_d;   // that data belongs to the bias row
  logic [NW-1:0]          kd_q, kd_d;       // input index of the returning data
  logic signed [AW-1:0]   acc_q [NUM_NODES];
  logic signed [AW-1:0]   acc_d [NUM_NODES];
  logic signed [DW-1:0]   act_q [NUM_NODES];
  logic signed [DW-1:0]   act_d [NUM_NODES];
  logic signed [DW-1:0]   scores_q [OUT_NODES];
  logic signed [DW-1:0]   scores_d [OUT_NODES];
  logic [CW-1:0]          class_q, class_d;
  logic                   ovf_q, ovf_d;

  logic [ADR_W-1:0]       n_len;
  logic signed [DW-1:0]   src;
  logic signed [2*DW-1:0] prod   [NUM_NODES];
  logic signed [AW-1:0]   shr    [NUM_NODES];
  logic signed [DW-1:0]   q_lane [NUM_NODES];
  logic [NUM_NODES-1:0]   clip;
  logic [CW-1:0]          best_idx;
  logic signed [DW-1:0]   best_val;

  assign n_len = (layer_q == '0) ? LEN_IN : LEN_HID;

  // Datapath: source select, per-lane products and requantisation.
  always_comb begin
    if (bias_q)             src = ONE;
    else if (layer_q == '0) src = DW'({pix_data, {PIX_SHIFT{1'b0}}});
    else                    src = act_q[kd_q];
    for (int i = 0; i < NUM_NODES; i++) begin
      prod[i] = src * $signed(w_data[DW*i +: DW]);
      shr[i]  = acc_q[i] >>> FRAC;
      clip[i] = 1'b0;
      if (shr[i] > Q_MAX) begin
        q_lane[i] = Q_MAX[DW-1:0];
        clip[i]   = 1'b1;
      end else if (shr[i] < Q_MIN) begin
        q_lane[i] = Q_MIN[DW-1:0];
        clip[i]   = 1'b1;
      end else begin
        q_lane[i] = shr[i][DW-1:0];
      end
    end
  end

  // Argmax: only a strictly greater score replaces the incumbent, so the
  // lowest index wins a tie.
  always_comb begin
    best_idx = '0;
    best_val = scores_q[0];
    for (int c = 1; c < OUT_NODES; c++) begin
      if (scores_q[c] > best_val) begin
        best_val = scores_q[c];
        best_idx = CW'(c);
      end
    end
  end

  // Next-state and control.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    k_d      = k_q;
    vld_d    = 1'b0;
    bias_d   = 1'b0;
    kd_d     = kd_q;
    acc_d    = acc_q;
    act_d    = act_q;
    scores_d = scores_q;
    class_d  = class_q;
    ovf_d    = ovf_q;

    if (vld_q) begin
      for (int i = 0; i < NUM_NODES; i++) acc_d[i] = acc_q[i] + AW'(prod[i]);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          layer_d = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          for (int i = 0; i < NUM_NODES; i++) acc_d[i] = '0;
        end
      end
      S_MAC: begin
        vld_d  = 1'b1;
        kd_d   = k_q[NW-1:0];
        bias_d = (k_q == n_len);
        if (k_q == n_len) state_d = S_FLUSH;
        else              k_d     = k_q + ADR_W'(1);
      end
      S_FLUSH: state_d = S_WRITE;
      S_WRITE: begin
        for (int i = 0; i < NUM_NODES; i++) acc_d[i] = '0;
        k_d = '0;
        if (layer_q == LAST_LAYER) begin
          for (int c = 0; c < OUT_NODES; c++) begin
            scores_d[c] = q_lane[c];
            if (clip[c]) ovf_d = 1'b1;
          end
          state_d = S_ARGMAX;
        end else begin
          for (int i = 0; i < NUM_NODES; i++) begin
            act_d[i] = q_lane[i][DW-1] ? '0 : q_lane[i];
            if (clip[i]) ovf_d = 1'b1;
          end
          layer_d = layer_q + LW'(1);
          state_d = S_MAC;
        end
      end
      S_ARGMAX: begin
        class_d = best_idx;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The pixel address follows k only while layer 0 is being streamed.
    pix_addr_d = (state_d == S_MAC && layer_d == '0) ? k_d : pix_addr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      layer_q    <= '0;
      k_q        <= '0;
      pix_addr_q <= '0;
      vld_q      <= 1'b0;
      bias_q     <= 1'b0;
      kd_q       <= '0;
      class_q    <= '0;
      ovf_q      <= 1'b0;
      // NOTE: the accumulators and activation buffer are register files, not
      // RAM macros, and an aborted inference must not leak values into the
      // next one, so they are cleared here as well.
      for (int i = 0; i < NUM_NODES; i++) begin
        acc_q[i] <= '0;
        act_q[i] <= '0;
      end
      for (int c = 0; c < OUT_NODES; c++) scores_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      k_q        <= k_d;
      pix_addr_q <= pix_addr_d;
      vld_q      <= vld_d;
      bias_q     <= bias_d;
      kd_q       <= kd_d;
      class_q    <= class_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      act_q      <= act_d;
      scores_q   <= scores_d;
    end
  end

  assign busy      = (state_q == S_MAC) || (state_q == S_FLUSH) ||
                     (state_q == S_WRITE) || (state_q == S_ARGMAX);
  assign done      = (state_q == S_DONE);
  assign pix_addr  = pix_addr_q;
  assign w_addr    = k_q;
  assign w_layer   = layer_q;
  assign class_idx = class_q;
  assign overflow  = ovf_q;

  for (genvar c = 0; c < OUT_NODES; c++) begin : g_scores
    assign scores[DW*c +: DW] = scores_q[c];
  end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Self-checking bench for nn_layer_engine: synchronous memory models for the
// pixel and weight stores, a scoreboard queue filled by the stimulus, and a
// monitor that checks every done pulse against the head of the queue.
module tb_nn_layer_engine;

  localparam int IN_LEN     = 256;
  localparam int NUM_NODES  = 15;
  localparam int OUT_NODES  = 10;
  localparam int NUM_LAYERS = 3;
  localparam int DW         = 16;
  localparam int FRAC       = 12;
  localparam int PIX_SHIFT  = 4;
  localparam int ADR_W      = $clog2(IN_LEN + 1);
  localparam int LW         = $clog2(NUM_LAYERS);
  localparam int CW         = $clog2(OUT_NODES);
  localparam int SW         = OUT_NODES * DW;
  localparam int BUSY_T     = (IN_LEN + 3) + (NUM_LAYERS - 1) * (NUM_NODES + 3) + 1;

  typedef struct packed {
    logic [SW-1:0] scores;
    logic [CW-1:0] cls;
    logic          ovf;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   busy, done, overflow;
  logic [ADR_W-1:0]       pix_addr, w_addr;
  logic [7:0]             pix_data;
  logic [LW-1:0]          w_layer;
  logic [NUM_NODES*DW-1:0] w_data;
  logic [SW-1:0]          scores;
  logic [CW-1:0]          class_idx;

  logic [7:0]             pix_mem [IN_LEN+1];
  logic signed [DW-1:0]   rom [NUM_LAYERS][IN_LEN+1][NUM_NODES];

  exp_t exp_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  nn_layer_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .w_layer   (w_layer),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .scores    (scores),
    .class_idx (class_idx),
    .overflow  (overflow)
  );

  // Synchronous memories, one-cycle read latency.
  always @(posedge clk) begin
    pix_data <= pix_mem[pix_addr];
    for (int i = 0; i < NUM_NODES; i++) w_data[DW*i +: DW] <= rom[w_layer][w_addr][i];
  end

  task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference: dense layers evaluated with plain integer arithmetic.
  function automatic exp_t model();
    exp_t   e;
    longint act [NUM_NODES];
    longint nxt [NUM_NODES];
    longint acc, q, best;
    int     n;
    e = '0;
    for (int i = 0; i < NUM_NODES; i++) act[i] = 0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      n = (l == 0) ? IN_LEN : NUM_NODES;
      for (int i = 0; i < NUM_NODES; i++) begin
        acc = (longint'(1) << FRAC) * longint'(rom[l][n][i]);
        for (int k = 0; k < n; k++)
          acc += ((l == 0) ? (longint'(pix_mem[k]) << PIX_SHIFT) : act[k]) * longint'(rom[l][k][i]);
        q = acc >>> FRAC;
        if (q > 32767 || q < -32768) begin
          q = (q > 0) ? 32767 : -32768;
          if (l < NUM_LAYERS - 1 || i < OUT_NODES) e.ovf = 1'b1;
        end
        nxt[i] = q;
      end
      if (l < NUM_LAYERS - 1) begin
        for (int i = 0; i < NUM_NODES; i++) act[i] = (nxt[i] < 0) ? 0 : nxt[i];
      end else begin
        best = nxt[0];
        for (int c = 0; c < OUT_NODES; c++) begin
          e.scores[DW*c +: DW] = nxt[c][DW-1:0];
          if (nxt[c] > best) begin
            best  = nxt[c];
            e.cls = CW'(c);
          end
        end
      end
    end
    return e;
  endfunction

  task automatic clear_mem();
    for (int k = 0; k <= IN_LEN; k++) begin
      pix_mem[k] = 8'd0;
      for (int l = 0; l < NUM_LAYERS; l++)
        for (int i = 0; i < NUM_NODES; i++) rom[l][k][i] = '0;
    end
  endtask

  // Random pixels and weights in [-wmax, wmax-1]; unused output lanes are zero.
  task automatic fill_random(input int wmax);
    for (int k = 0; k <= IN_LEN; k++) begin
      pix_mem[k] = (k < IN_LEN) ? 8'($urandom_range(0, 255)) : 8'd0;
      for (int l = 0; l < NUM_LAYERS; l++)
        for (int i = 0; i < NUM_NODES; i++)
          rom[l][k][i] = (l == NUM_LAYERS - 1 && i >= OUT_NODES) ? '0 :
                         DW'(int'($urandom_range(0, 2 * wmax - 1)) - wmax);
    end
  endtask

  // Monitor: every done pulse is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("scores", scores, e.scores);
          check("class_idx", class_idx, e.cls);
          check("overflow", overflow, e.ovf);
          check("busy_in_done", busy, 0);
          check("busy_cycles", busy_cnt, BUSY_T);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  // One inference; optionally pokes start mid-run, which must be ignored.
  task automatic run_one(input exp_t e, input bit poke_busy);
    exp_q.push_back(e);
    pulse_start();
    if (poke_busy) begin
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(BUSY_T + 20);
    repeat (5) @(negedge clk);
    check("hold_scores", scores, e.scores);
    check("hold_class", class_idx, e.cls);
    check("hold_overflow", overflow, e.ovf);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_scores", scores, 0);
    check("rst_class", class_idx, 0);
    check("rst_overflow", overflow, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_layer", w_layer, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cyc, last, n_done;

    reset = 1'b0;
    start = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;

    // All weights zero.
    for (int k = 0; k < IN_LEN; k++) pix_mem[k] = 8'($urandom_range(0, 255));
    e = '0;
    run_one(e, 1'b0);

    // Single bright pixel propagated through identity to class 7.
    clear_mem();
    pix_mem[0] = 8'd255;
    for (int k = 0; k < IN_LEN; k++)
      for (int i = 0; i < NUM_NODES; i++) rom[0][k][i] = 16'sd4096;
    for (int k = 0; k < NUM_NODES; k++) rom[1][k][k] = 16'sd4096;
    rom[2][3][7] = 16'sd8192;
    e = '0;
    e.scores[DW*7 +: DW] = 16'sd8160;
    e.cls = CW'(7);
    run_one(e, 1'b0);

    // Hidden saturation sets sticky overflow.
    clear_mem();
    for (int k = 0; k < IN_LEN; k++) begin
      pix_mem[k] = 8'd255;
      for (int i = 0; i < NUM_NODES; i++) rom[0][k][i] = 16'sh7FFF;
    end
    e = '0;
    e.ovf = 1'b1;
    run_one(e, 1'b0);

    // ReLU on a negative hidden lane, equal negative scores tie to class 0.
    clear_mem();
    for (int k = 0; k < IN_LEN; k++) pix_mem[k] = 8'($urandom_range(0, 255));
    rom[0][IN_LEN][2] = -16'sd4096;
    for (int c = 0; c < OUT_NODES; c++) rom[2][NUM_NODES][c] = -16'sd100;
    e = '0;
    for (int c = 0; c < OUT_NODES; c++) e.scores[DW*c +: DW] = -16'sd100;
    run_one(e, 1'b0);

    // Randomised images and weights against the reference model.
    fill_random(16);
    run_one(model(), 1'b1);
    fill_random(64);
    run_one(model(), 1'b0);
    fill_random(1024);
    run_one(model(), 1'b0);

    // Reset in the middle of an inference: abort, no done.
    fill_random(32);
    pulse_start();
    repeat (99) @(negedge clk);
    check("busy_before_abort", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    n_done = 0;
    repeat (BUSY_T + 10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_done_after_abort", n_done, 0);
    run_one(model(), 1'b0);

    // start held high: back-to-back inferences every BUSY_T + 2 cycles.
    fill_random(48);
    e = model();
    for (int r = 0; r < 3; r++) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    last = 0;
    for (int r = 0; r < 3; r++) begin
      n_done = 0;
      while (!done && n_done < BUSY_T + 20) begin
        @(negedge clk);
        cyc++;
        n_done++;
      end
      check("held_done_seen", done, 1);
      if (r > 0) check("held_period", cyc - last, BUSY_T + 2);
      last = cyc;
      if (r == 2) begin
        start = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    repeat (10) @(negedge clk);
    check("held_idle_after", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
